video_scanlines: RTL and testbench
==================================

VIDEO_SCANLINES -- requirements
Module: video_scanlines

Interface
REQ-001 SHALL have parameter BITS, default 8, giving the per-channel colour width (legal 4..8).
REQ-002 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ce_pix, input, 1 bit: the output pixel enable of the upstream scandoubler.
REQ-005 SHALL have port scanlines, input, 2 bits: mode select (0 off, 1 dims to 75%, 2 to 50%, 3 to 25%).
REQ-006 SHALL have ports hs_in, vs_in, hb_in and vb_in, each an input of 1 bit: doubled-rate syncs and blanks, active high.
REQ-007 SHALL have ports r_in, g_in and b_in, each an input of BITS bits: doubled-rate colour.
REQ-008 SHALL have ports hs_out, vs_out, hb_out and vb_out, each an output of 1 bit: delayed syncs and blanks.
REQ-009 SHALL have ports r_out, g_out and b_out, each an output of BITS bits: processed colour.

Function
REQ-010 SHALL update every register only in a clk_sys cycle where ce_pix=1, except for reset; with ce_pix=0, all state holds.
REQ-011 SHALL use a 2-stage pipeline: in stage 1, register the inputs and the edge-detect history; in stage 2, register the outputs.
REQ-012 SHALL make every output, colour and sync alike, equal its input exactly 2 ce_pix cycles earlier, so syncs stay aligned with colour.
REQ-013 SHALL detect hs falling (hs_d=1, hs_in=0) and vs rising (vs_d=0, vs_in=1), both sampled on ce_pix.
REQ-014 SHALL use a line-parity flag dark: toggle it on each hs falling edge; on a vs rising edge, load it with the frame-start value (REQ-022).
REQ-015 SHALL let the vs-rising load win over the hs-falling toggle when both edges occur on the same ce_pix.
REQ-016 SHALL latch the mode register mode_q from scanlines only on a vs rising edge, so a change mid-frame takes effect on the next frame.
REQ-017 SHALL pass colour unchanged when dark=0 or mode_q=0.
REQ-018 SHALL, when dark=1 and mode_q=1, output each channel as c - (c>>2), truncated with no rounding.
REQ-019 SHALL, when dark=1 and mode_q=2, output each channel as c>>1.
REQ-020 SHALL, when dark=1 and mode_q=3, output each channel as c>>2.
REQ-021 SHALL, when stage-1 hb or vb is 1, output colour 0 regardless of mode; the blank outputs themselves are unaffected.
REQ-022 SHALL use a frame-start value of 0, so the first line after vs is bright (see Configuration).
REQ-023 SHALL keep all arithmetic at BITS width, with no overflow possible: results are at most c.
REQ-024 SHALL have no wrap-around hazard in the parity flag, which is a single bit with unlimited lines per frame.

Reset
REQ-025 SHALL, on reset=1 at a clk_sys edge, clear all outputs to 0, the pipeline to 0, dark to the frame-start value, mode_q to 0, and the hs/vs history to 0; this applies regardless of ce_pix.
REQ-026 SHALL, on reset during active video, start output at the next ce_pix after release from the cleared pipeline, with no partial pixel emitted.
REQ-027 SHALL, after reset, bright-pass (mode_q=0) until the first vs rising edge latches scanlines.

Configuration
REQ-028 SHALL, with macro SCANLINES_PARITY_EN defined, add input scan_odd (1 bit, after scanlines); its value on a vs rising edge is the frame-start value of dark, so the first line is dark when scan_odd=1.
REQ-029 SHALL, with SCANLINES_PARITY_EN undefined, not have the scan_odd port and use a fixed frame-start value of 0.

Verification
REQ-030 SHALL cover: BITS=8, scanlines=2 before vs, r=g=b=0xC8 constant, 4 lines -> lines 0 and 2 output 0xC8, lines 1 and 3 output 0x64.
REQ-031 SHALL cover: scanlines=1 with c=0xFF -> dark lines 0xC0; scanlines=3 with c=0xFF -> 0x3F; 0x03 with mode 1 -> 0x03.
REQ-032 SHALL cover: single-cycle pulse on hs_in and a colour step on a given ce_pix -> both appear at the outputs exactly 2 ce_pix later; with ce_pix held at 0 for 5 cycles, the outputs are frozen.
REQ-033 SHALL cover: scanlines changed 0->2 mid-frame -> no dimming until the next vs rise, then dimming on the odd lines.
REQ-034 SHALL cover: hs falling and vs rising on the same ce_pix -> dark is set to the frame-start value, not toggled.
REQ-035 SHALL cover: hb_in=1 with c=0xFF -> colour out 0x00 and hb_out=1 after 2 ce_pix; reset asserted mid-line -> all outputs 0 on the next clk_sys.

Source files
------------

// File: rtl/video_scanlines.sv
// Scanline dimmer behind a scandoubler: two-stage pipeline that darkens alternate lines.
// Define SCANLINES_PARITY_EN to add scan_odd, which selects the frame's first-line parity.
module video_scanlines #(
  parameter int BITS = 8
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic [1:0]      scanlines,
`ifdef SCANLINES_PARITY_EN
  input  logic            scan_odd,
`endif
  input  logic            hs_in,
  input  logic            vs_in,
  input  logic            hb_in,
  input  logic            vb_in,
  input  logic [BITS-1:0] r_in,
  input  logic [BITS-1:0] g_in,
  input  logic [BITS-1:0] b_in,
  output logic            hs_out,
  output logic            vs_out,
  output logic            hb_out,
  output logic            vb_out,
  output logic [BITS-1:0] r_out,
  output logic [BITS-1:0] g_out,
  output logic [BITS-1:0] b_out
);

  logic            hs1, vs1, hb1, vb1;
  logic [BITS-1:0] r1, g1, b1;
  logic            dark;
  logic [1:0]      mode_q;
  logic            start;
  logic            hs_fall, vs_rise;
  logic [BITS-1:0] r_c, g_c, b_c;

`ifdef SCANLINES_PARITY_EN
  assign start = scan_odd;
`else
  assign start = 1'b0;
`endif

  // Stage-1 sync registers double as the edge-detect history.
  assign hs_fall = hs1 & ~hs_in;
  assign vs_rise = ~vs1 & vs_in;

  function automatic logic [BITS-1:0] dim(
    input logic [BITS-1:0] c,
    input logic [1:0]      m,
    input logic            d
  );
    logic [BITS-1:0] v;
    v = c;
    if (d) begin
      unique case (m)
        2'd1:    v = c - (c >> 2);
        2'd2:    v = c >> 1;
        2'd3:    v = c >> 2;
        default: v = c;
      endcase
    end
    return v;
  endfunction

  always_comb begin
    r_c = dim(r1, mode_q, dark);
    g_c = dim(g1, mode_q, dark);
    b_c = dim(b1, mode_q, dark);
    if (hb1 | vb1) begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      hb1    <= 1'b0;
      vb1    <= 1'b0;
      r1     <= '0;
      g1     <= '0;
      b1     <= '0;
      dark   <= start;
      mode_q <= 2'd0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      hb_out <= 1'b0;
      vb_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else if (ce_pix) begin
      hs1 <= hs_in;
      vs1 <= vs_in;
      hb1 <= hb_in;
      vb1 <= vb_in;
      r1  <= r_in;
      g1  <= g_in;
      b1  <= b_in;
      // Frame start overrides a coincident line toggle.
      if (vs_rise) begin
        dark   <= start;
        mode_q <= scanlines;
      end else if (hs_fall) begin
        dark <= ~dark;
      end
      hs_out <= hs1;
      vs_out <= vs1;
      hb_out <= hb1;
      vb_out <= vb1;
      r_out  <= r_c;
      g_out  <= g_c;
      b_out  <= b_c;
    end
  end

endmodule

// File: tb/tb_video_scanlines.sv
// Scoreboard bench for video_scanlines: driver queues expected pixels,
// monitor pops one per ce_pix once two are in flight.
module tb_video_scanlines;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [1:0] scanlines = 2'd0;
  logic       hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_out, vs_out, hb_out, vb_out;
  logic [7:0] r_out, g_out, b_out;

  localparam logic [3:0] HS = 4'b1000;
  localparam logic [3:0] VS = 4'b0100;
  localparam logic [3:0] HB = 4'b0010;
  localparam logic [3:0] VB = 4'b0001;

  video_scanlines #(.BITS(8)) dut (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix),
    .scanlines(scanlines),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  logic [27:0] q[$];
  logic [27:0] last_exp = '0;
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [27:0] got,
                       input logic [27:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s @%0t: got %h required %h", name, $time, got, exp);
  endtask

  function automatic logic [27:0] outs();
    return {hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_exp = '0;
        check("reset", outs(), '0);
      end else if (ce_pix) begin
        if (q.size() >= 2) last_exp = q.pop_front();
        else last_exp = '0;
        check("pixel", outs(), last_exp);
      end else begin
        check("hold", outs(), last_exp);
      end
    end
  end

  task automatic px(input logic [3:0] ctl,
                    input logic [7:0] r, input logic [7:0] g,
                    input logic [7:0] b, input logic [7:0] er,
                    input logic [7:0] eg, input logic [7:0] eb);
    @(negedge clk);
    ce_pix = 1'b1;
    {hs_in, vs_in, hb_in, vb_in} = ctl;
    r_in = r;
    g_in = g;
    b_in = b;
    q.push_back({ctl, er, eg, eb});
  endtask

  task automatic pc(input logic [3:0] ctl, input logic [7:0] c,
                    input logic [7:0] e);
    px(ctl, c, c, c, e, e, e);
  endtask

  task automatic line(input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic [7:0] er,
                      input logic [7:0] eg, input logic [7:0] eb,
                      input int n);
    repeat (n) px(4'b0000, r, g, b, er, eg, eb);
    px(HS, r, g, b, er, eg, eb);
  endtask

  task automatic lc(input logic [7:0] c, input logic [7:0] e);
    line(c, c, c, e, e, e, 2);
  endtask

  task automatic frame();
    pc(VS | VB, 8'h11, 8'h00);
    pc(VB, 8'h22, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce_pix = 1'b0;
      hs_in = ~hs_in;
      r_in = 8'hAA;
      g_in = 8'h55;
      b_in = 8'hAA;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ce_pix = 1'b0;
    q.delete();
    @(negedge clk);
    ce_pix = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ce_pix = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // Four lines at 50% after vs latches mode 2
    scanlines = 2'd2;
    pc(4'b0000, 8'h55, 8'h55);
    frame();
    lc(8'hC8, 8'hC8);
    lc(8'hC8, 8'h64);
    lc(8'hC8, 8'hC8);
    lc(8'hC8, 8'h64);
    // vs rise coincides with hs fall: parity reloads, first line bright
    scanlines = 2'd1;
    frame();
    lc(8'hFF, 8'hFF);
    line(8'hFF, 8'h03, 8'h80, 8'hC0, 8'h03, 8'h60, 2);
    scanlines = 2'd3;
    frame();
    lc(8'hFF, 8'hFF);
    lc(8'hFF, 8'h3F);
    // Mid-frame mode change waits for the next vs
    scanlines = 2'd0;
    frame();
    lc(8'hC8, 8'hC8);
    scanlines = 2'd2;
    lc(8'hC8, 8'hC8);
    lc(8'hC8, 8'hC8);
    frame();
    lc(8'hC8, 8'hC8);
    lc(8'hC8, 8'h64);
    // Latency and freeze with an hs pulse in flight
    pc(4'b0000, 8'h10, 8'h10);
    pc(4'b0000, 8'h10, 8'h10);
    pc(HS, 8'h40, 8'h40);
    idle(5);
    pc(4'b0000, 8'h40, 8'h20);
    pc(4'b0000, 8'h40, 8'h20);
    // Blanking forces black
    pc(HB, 8'hFF, 8'h00);
    pc(HB | VB, 8'hFF, 8'h00);
    pc(4'b0000, 8'h30, 8'h18);
    // Reset mid-line, then bright until a vs latches the mode
    do_reset();
    pc(4'b0000, 8'h80, 8'h80);
    line(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1);
    line(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1);
    frame();
    line(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1);
    line(8'h80, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 1);
    pc(4'b0000, 8'h00, 8'h00);
    pc(4'b0000, 8'h00, 8'h00);
    idle(2);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
